// File: rtl/apb_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_sram_pkg
// Description : Shared types and helpers for the APB SRAM completer.
//               - state_t   : completer FSM states
//               - err_t     : response error classification
//               - WAIT_*    : wait-state generation modes
//               - lfsr16_step : one step of a 16-bit Galois LFSR
//                               (taps 16,14,13,11)
// Revision    : 1.0 - initial release
// ============================================================================
package apb_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WAIT_FIXED  = 0;
    localparam int WAIT_RANDOM = 1;

    typedef enum logic [1:0] {
        OK        = 2'd0,
        MISALIGN  = 2'd1,
        RANGE     = 2'd2,
        UNWRITTEN = 2'd3
    } err_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage : apb_sram_pkg
`default_nettype wire

// File: rtl/apb_sram_waitgen.sv
`default_nettype none
// ============================================================================
// Module      : apb_sram_waitgen
// Description : Supplies the wait-state count for the next APB transfer.
//               Fixed mode returns WAIT_CYCLES; random mode returns the low
//               bits of a free-standing LFSR that steps once per accepted
//               setup phase.
// Ports       : _PCLK       in   clock
//               _PRESETn    in   asynchronous active-low reset
//               adv_i       in   setup accepted this cycle (step the LFSR)
//               wait_cnt_o  out  wait count for the transfer being set up
// Revision    : 1.0 - initial release
// ============================================================================
module apb_sram_waitgen
    import apb_sram_pkg::*;
#(
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          MAX_WAIT    = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CNT_W       = 2
) (
    input  logic             _PCLK,
    input  logic             _PRESETn,
    input  logic             adv_i,
    output logic [CNT_W-1:0] wait_cnt_o
);

    // MAX_WAIT is 2^k-1, so k low LFSR bits cover exactly 0..MAX_WAIT.
    localparam int RND_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = adv_i ? lfsr16_step(lfsr_q) : lfsr_q;

    always_ff @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The count presented during setup is the pre-step LFSR value, so the
    // first random transfer after reset uses LFSR_SEED's low bits.
    assign wait_cnt_o = (WAIT_MODE == WAIT_RANDOM) ? CNT_W'(lfsr_q[RND_W-1:0])
                                                   : CNT_W'(WAIT_CYCLES);

endmodule : apb_sram_waitgen
`default_nettype wire

// File: rtl/apb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_sram_slave
// Description : APB4 completer backed by a DEPTH x DATA_W word array with
//               byte strobes, per-word written tracking and fixed or
//               pseudo-random wait states. PSLVERR flags misaligned,
//               out-of-range and unwritten-read accesses (in that priority).
// Ports       : _PCLK, _PRESETn        clock, async active-low reset
//               _PSEL, _PENABLE        APB phase control
//               _PWRITE                transfer direction
//               _PADDR   [ADDR_W]      byte address
//               _PWDATA  [DATA_W]      write data
//               _PSTRB   [DATA_W/8]    write byte strobes
//               _PRDATA  [DATA_W]      read data (0 on error and writes)
//               _PREADY                transfer completes when high
//               _PSLVERR               error response, qualified by _PREADY
// Revision    : 1.0 - initial release
// ============================================================================
module apb_sram_slave
    import apb_sram_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 32,
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          MAX_WAIT    = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  _PCLK,
    input  logic                  _PRESETn,
    input  logic                  _PSEL,
    input  logic                  _PENABLE,
    input  logic                  _PWRITE,
    input  logic [ADDR_W-1:0]     _PADDR,
    input  logic [DATA_W-1:0]     _PWDATA,
    input  logic [DATA_W/8-1:0]   _PSTRB,
    output logic [DATA_W-1:0]     _PRDATA,
    output logic                  _PREADY,
    output logic                  _PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RND_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int FIX_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int CNT_W  = (WAIT_MODE == WAIT_RANDOM) ? RND_W : FIX_W;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFS) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pready_q;
    logic                   pslverr_q;
    logic [DATA_W-1:0]      prdata_q;
    logic [DEPTH-1:0]       valid_q;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Address decode and error classification
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]      w_word;
    logic [IDX_W-1:0]       w_idx;
    err_t                   w_err;
    logic [DATA_W-1:0]      w_rdata;
    logic                   w_setup;
    logic                   w_commit;
    logic [CNT_W-1:0]       w_wait_cnt;

    assign w_word = _PADDR >> OFFS;
    assign w_idx  = w_word[IDX_W-1:0];

    // The valid lookup is reached only once the range check has passed, so
    // w_idx is always a real word there even when DEPTH is not 2^n.
    always_comb begin
        w_err = OK;
        if ((_PADDR & OFF_MASK) != '0) begin
            w_err = MISALIGN;
        end else if (w_word >= DEPTH_A) begin
            w_err = RANGE;
        end else if (!_PWRITE && !valid_q[w_idx]) begin
            w_err = UNWRITTEN;
        end
    end

    assign w_rdata  = ((w_err == OK) && !_PWRITE) ? mem_q[w_idx] : '0;
    assign w_setup  = (state_q == IDLE) && _PSEL && !_PENABLE;
    assign w_commit = (state_q == RESP) && _PSEL && _PENABLE && _PWRITE
                      && (w_err == OK);

    // ------------------------------------------------------------------
    // Wait-count source
    // ------------------------------------------------------------------
    apb_sram_waitgen #(
        .WAIT_MODE   (WAIT_MODE),
        .WAIT_CYCLES (WAIT_CYCLES),
        .MAX_WAIT    (MAX_WAIT),
        .LFSR_SEED   (LFSR_SEED),
        .CNT_W       (CNT_W)
    ) u_waitgen (
        ._PCLK       (_PCLK),
        ._PRESETn    (_PRESETn),
        .adv_i       (w_setup),
        .wait_cnt_o  (w_wait_cnt)
    );

    // ------------------------------------------------------------------
    // Transfer FSM with registered response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            valid_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_setup) begin
                        if (w_wait_cnt == '0) begin
                            // Zero waits: respond in the first access cycle.
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= (w_err != OK);
                            prdata_q  <= w_rdata;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= w_wait_cnt;
                        end
                    end
                end
                WAIT: begin
                    if (!_PSEL) begin
                        state_q <= IDLE;
                    end else if (_PENABLE) begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= (w_err != OK);
                            prdata_q  <= w_rdata;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Completion edge, or the requester dropped PSEL.
                    if (!_PSEL || _PENABLE) begin
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                        if (w_commit && (_PSTRB != '0)) begin
                            valid_q[w_idx] <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge _PCLK) begin
        if (w_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (_PSTRB[b]) begin
                    mem_q[w_idx][b*8 +: 8] <= _PWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign _PREADY  = pready_q;
    assign _PSLVERR = pslverr_q;
    assign _PRDATA  = prdata_q;

endmodule : apb_sram_slave
`default_nettype wire

// File: tb/tb_apb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_sram_slave
// Description : Self-checking bench for apb_sram_slave. Three instances share
//               one APB bus (separate PSEL): zero fixed waits, three fixed
//               waits, and LFSR-random waits with MAX_WAIT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_sram_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    apb_sram_slave #(.WAIT_MODE(0), .WAIT_CYCLES(0)) u_fix0 (
        ._PCLK(clk), ._PRESETn(rstn), ._PSEL(psel[0]), ._PENABLE(penable),
        ._PWRITE(pwrite), ._PADDR(paddr), ._PWDATA(pwdata), ._PSTRB(pstrb),
        ._PRDATA(prdata[0]), ._PREADY(pready[0]), ._PSLVERR(pslverr[0]));

    apb_sram_slave #(.WAIT_MODE(0), .WAIT_CYCLES(3)) u_fix3 (
        ._PCLK(clk), ._PRESETn(rstn), ._PSEL(psel[1]), ._PENABLE(penable),
        ._PWRITE(pwrite), ._PADDR(paddr), ._PWDATA(pwdata), ._PSTRB(pstrb),
        ._PRDATA(prdata[1]), ._PREADY(pready[1]), ._PSLVERR(pslverr[1]));

    apb_sram_slave #(.WAIT_MODE(1), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)) u_rnd (
        ._PCLK(clk), ._PRESETn(rstn), ._PSEL(psel[2]), ._PENABLE(penable),
        ._PWRITE(pwrite), ._PADDR(paddr), ._PWDATA(pwdata), ._PSTRB(pstrb),
        ._PRDATA(prdata[2]), ._PREADY(pready[2]), ._PSLVERR(pslverr[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Starts just after a clock edge and returns just after the completion
    // edge, so consecutive calls are back-to-back with no idle cycle.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er,
                        output int nw, output int ncyc);
        int unsigned c0;
        c0      = cyc;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        rd      = '0;
        er      = 1'b0;
        nw      = 0;
        @(posedge clk); #1;
        penable = 1'b1;
        forever begin
            @(negedge clk);
            if (pready[d]) begin
                rd = prdata[d];
                er = pslverr[d];
                break;
            end
            nw++;
            if (nw > 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL pready_timeout: got no PREADY after %0d cycles, expected completion", nw);
                break;
            end
        end
        @(posedge clk); #1;
        ncyc    = int'(cyc - c0);
        psel    = '0;
        penable = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    int waits1 [200];
    int waits2 [200];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nw;
        int          nc;
        logic [3:0]  seen;

        vt[0]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        1'b1}; // unwritten
        vt[1]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vt[2]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vt[3]  = '{1'b1, 32'h08, 32'h11223344, 4'h5, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vt[5]  = '{1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1}; // misaligned
        vt[6]  = '{1'b0, 32'h06, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[7]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vt[8]  = '{1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1}; // range
        vt[9]  = '{1'b0, 32'h80, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[10] = '{1'b0, 32'h7C, 32'h0,        4'h0, 32'h0,        1'b1}; // last word unwritten
        vt[11] = '{1'b1, 32'h7C, 32'hA5A55A5A, 4'hF, 32'h0,        1'b0};
        vt[12] = '{1'b0, 32'h7C, 32'h0,        4'h0, 32'hA5A55A5A, 1'b0};
        vt[13] = '{1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0,        1'b0}; // zero strobe
        vt[14] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[15] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};

        rstn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_pready",  {31'd0, pready[i]},  32'd0);
            chk("reset_pslverr", {31'd0, pslverr[i]}, 32'd0);
            chk("reset_prdata",  prdata[i],           32'd0);
        end
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Table: zero-wait instance
        for (int i = 0; i < NV; i++) begin
            xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, nw, nc);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].err});
            chk($sformatf("vec%0d_cycles", i), nc, 32'd2);
        end

        // Outputs return to zero the cycle after an error completion
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, nw, nc);
        @(negedge clk);
        chk("post_pready",  {31'd0, pready[0]},  32'd0);
        chk("post_pslverr", {31'd0, pslverr[0]}, 32'd0);
        chk("post_prdata",  prdata[0],           32'd0);
        @(posedge clk); #1;

        // Three fixed waits: back-to-back write then read, 5 + 5 cycles
        xfer(1, 1'b1, 32'h20, 32'h0BADCAFE, 4'hF, rd, er, nw, nc);
        chk("w3_write_waits",  nw, 32'd3);
        chk("w3_write_cycles", nc, 32'd5);
        chk("w3_write_err",    {31'd0, er}, 32'd0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, nw, nc);
        chk("w3_read_waits",  nw, 32'd3);
        chk("w3_read_cycles", nc, 32'd5);
        chk("w3_read_data",   rd, 32'h0BADCAFE);

        // PENABLE dropped during WAIT: counter holds
        psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; pstrb = 4'h0;
        @(posedge clk); #1 penable = 1'b1;          // access: count 3 -> 2
        @(posedge clk); #1 penable = 1'b0;          // held
        @(posedge clk); #1;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("hold_pready_a", {31'd0, pready[1]}, 32'd0);
        @(negedge clk);                             // count 2 -> 1
        chk("hold_pready_b", {31'd0, pready[1]}, 32'd0);
        @(negedge clk);                             // 1 -> response
        chk("hold_pready_c",  {31'd0, pready[1]},  32'd1);
        chk("hold_pslverr",   {31'd0, pslverr[1]}, 32'd0);
        chk("hold_prdata",    prdata[1],           32'h0BADCAFE);
        @(posedge clk); #1 psel = '0; penable = 1'b0;

        // Random waits: range, coverage, seed-derived start, repeatability
        do_reset();
        seen = '0;
        for (int i = 0; i < 200; i++) begin
            xfer(2, 1'b1, 32'h00, i, 4'hF, rd, er, nw, nc);
            waits1[i] = nw;
            chk("rnd_range",  {31'd0, (nw <= 3)}, 32'd1);
            chk("rnd_cycles", nc, nw + 2);
            if (nw <= 3) seen[nw] = 1'b1;
        end
        chk("rnd_all_values", {28'd0, seen}, 32'hF);
        chk("rnd_first",  waits1[0], 32'd1);   // 0xACE1 & 3
        chk("rnd_second", waits1[1], 32'd0);   // step -> 0xE270 & 3
        do_reset();
        for (int i = 0; i < 200; i++) begin
            xfer(2, 1'b1, 32'h00, i, 4'hF, rd, er, nw, nc);
            waits2[i] = nw;
            chk($sformatf("rnd_repeat%0d", i), waits2[i], waits1[i]);
        end

        // Reset during the WAIT of a write; the word stays unwritten
        xfer(1, 1'b1, 32'h20, 32'h600DF00D, 4'hF, rd, er, nw, nc);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
        pwdata = 32'h55AA55AA; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_pready", {31'd0, pready[1]}, 32'd0);
        @(posedge clk); #1 psel = '0; penable = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, nw, nc);
        chk("midrst_err",   {31'd0, er}, 32'd1);
        chk("midrst_rdata", rd,          32'd0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, nw, nc);
        chk("rst_clears_valid", {31'd0, er}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_apb_sram_slave
`default_nettype wire
